// File: rtl/dct_ctrl_pkg.sv
// Shared definitions for the serial DCT frame controller: block-size codes, size decode, TX FSM states.
// Purely combinational helpers; no state, no handshakes.
package dct_ctrl_pkg;

  localparam logic [2:0] SZ_4  = 3'd0;
  localparam logic [2:0] SZ_8  = 3'd1;
  localparam logic [2:0] SZ_16 = 3'd2;
  localparam logic [2:0] SZ_32 = 3'd3;

  typedef logic [2:0] tx_state_t;

  localparam tx_state_t ST_IDLE  = 3'd0;
  localparam tx_state_t ST_START = 3'd1;
  localparam tx_state_t ST_LOAD  = 3'd2;
  localparam tx_state_t ST_SHIFT = 3'd3;
  localparam tx_state_t ST_WAIT  = 3'd4;

  // Points per block; reserved codes decode to 0.
  function automatic logic [5:0] size_to_n(input logic [2:0] size);
    case (size)
      SZ_4:    return 6'd4;
      SZ_8:    return 6'd8;
      SZ_16:   return 6'd16;
      SZ_32:   return 6'd32;
      default: return 6'd0;
    endcase
  endfunction

  function automatic logic size_reserved(input logic [2:0] size);
    return size[2];
  endfunction

endpackage

// File: rtl/dct_serdes_rx.sv
// Collects CW-bit coefficients MSB-first from the core; strobe lands one cycle after the last bit.
// No backpressure on either side; everything clears whenever en is low.
module dct_serdes_rx
  import dct_ctrl_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [2:0]    size,
  input  logic          sdat,
  input  logic          sval,
  output logic [CW-1:0] coef_dat,
  output logic          coef_vld,
  output logic [4:0]    coef_idx,
  output logic          coef_last,
  output logic          done
);

  localparam int BW = $clog2(CW);

  logic [CW-2:0] sreg;
  logic [BW-1:0] bit_cnt;
  logic [4:0]    idx;
  logic [5:0]    n;
  logic [CW-1:0] word;

  assign n    = size_to_n(size);
  assign word = {sreg, sdat};

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      sreg      <= '0;
      bit_cnt   <= '0;
      idx       <= '0;
      coef_dat  <= '0;
      coef_vld  <= 1'b0;
      coef_idx  <= '0;
      coef_last <= 1'b0;
      done      <= 1'b0;
    end else begin
      coef_vld  <= 1'b0;
      coef_last <= 1'b0;
      done      <= 1'b0;
      if (sval) begin
        sreg <= word[CW-2:0];
        if (bit_cnt == BW'(CW - 1)) begin
          bit_cnt  <= '0;
          coef_dat <= word;
          coef_vld <= 1'b1;
          coef_idx <= idx;
          if ({1'b0, idx} == n - 6'd1) begin
            coef_last <= 1'b1;
            done      <= 1'b1;
            idx       <= '0;
          end else begin
            idx <= idx + 5'd1;
          end
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dct_serial_frame_ctrl.sv
// Runs one block through the serial DCT core: START strobe, then per sample a LOAD handshake and DW serial bits.
// Sample input stalls in LOAD only; coefficient output has no backpressure; watchdog aborts a silent core.
module dct_serial_frame_ctrl
  import dct_ctrl_pkg::*;
#(
  parameter int DW  = 16,
  parameter int CW  = 16,
  parameter int TMO = 1024
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic [2:0]    iCfgSize,
  input  logic          iStart,
  output logic          oBusy,
  output logic          oDone,
  output logic          oErr,
  input  logic [DW-1:0] iSmpData,
  input  logic          iSmpValid,
  output logic          oSmpReady,
  output logic [2:0]    oCoreSize,
  output logic          oCoreValid,
  output logic          oCoreSDAT,
  output logic          oCoreSVAL,
  input  logic          iCoreSDAT,
  input  logic          iCoreSVAL,
  output logic [CW-1:0] oCoefData,
  output logic          oCoefValid,
  output logic [4:0]    oCoefIdx,
  output logic          oCoefLast
);

  localparam int BW = $clog2(DW);
  localparam int WW = $clog2(TMO + 1);

  tx_state_t     state;
  logic [2:0]    size_q;
  logic [DW-1:0] sreg;
  logic [BW-1:0] bit_cnt;
  logic [5:0]    smp_cnt;
  logic [WW-1:0] wd_cnt;
  logic          err_q;
  logic          done_seen;
  logic          rx_done;
  logic [5:0]    n;
  logic          busy;

  assign n    = size_to_n(size_q);
  assign busy = (state != ST_IDLE);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state     <= ST_IDLE;
      size_q    <= '0;
      sreg      <= '0;
      bit_cnt   <= '0;
      smp_cnt   <= '0;
      wd_cnt    <= '0;
      err_q     <= 1'b0;
      done_seen <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (iStart) begin
            if (size_reserved(iCfgSize)) begin
              err_q <= 1'b1;
            end else begin
              size_q <= iCfgSize;
              state  <= ST_START;
            end
          end
        end
        ST_START: begin
          smp_cnt   <= '0;
          done_seen <= 1'b0;
          state     <= ST_LOAD;
        end
        ST_LOAD: begin
          if (iSmpValid) begin
            sreg    <= iSmpData;
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sreg    <= {sreg[DW-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BW'(DW - 1)) begin
            smp_cnt <= smp_cnt + 6'd1;
            wd_cnt  <= '0;
            state   <= (smp_cnt == n - 6'd1) ? ST_WAIT : ST_LOAD;
          end
        end
        ST_WAIT: begin
          if (rx_done || done_seen) begin
            state <= ST_IDLE;
          end else if (iCoreSVAL) begin
            wd_cnt <= '0;
          end else if (wd_cnt == WW'(TMO - 1)) begin
            err_q <= 1'b1;
            state <= ST_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // The core may finish emitting before the last sample has been shifted out.
      if (rx_done && state != ST_WAIT) begin
        done_seen <= 1'b1;
      end
    end
  end

  assign oBusy      = busy;
  assign oErr       = err_q;
  assign oDone      = rx_done;
  assign oSmpReady  = (state == ST_LOAD);
  assign oCoreSize  = busy ? size_q : 3'd0;
  assign oCoreValid = (state == ST_START);
  assign oCoreSVAL  = (state == ST_SHIFT);
  assign oCoreSDAT  = (state == ST_SHIFT) & sreg[DW-1];

  dct_serdes_rx #(
    .CW(CW)
  ) u_rx (
    .clk      (iClk),
    .rst      (iRst),
    .en       (busy),
    .size     (size_q),
    .sdat     (iCoreSDAT),
    .sval     (iCoreSVAL),
    .coef_dat (oCoefData),
    .coef_vld (oCoefValid),
    .coef_idx (oCoefIdx),
    .coef_last(oCoefLast),
    .done     (rx_done)
  );

endmodule

// File: tb/tb_dct_serial_frame_ctrl.sv
// Directed bench for dct_serial_frame_ctrl: negedge monitor records DUT activity, main thread drives and checks.
module tb_dct_serial_frame_ctrl;
  import dct_ctrl_pkg::*;

  localparam int DW  = 16;
  localparam int CW  = 16;
  localparam int TMO = 1024;

  logic          iClk = 1'b0;
  logic          iRst = 1'b1;
  logic [2:0]    iCfgSize = '0;
  logic          iStart = 1'b0;
  logic          oBusy, oDone, oErr;
  logic [DW-1:0] iSmpData = '0;
  logic          iSmpValid = 1'b0;
  logic          oSmpReady;
  logic [2:0]    oCoreSize;
  logic          oCoreValid, oCoreSDAT, oCoreSVAL;
  logic          iCoreSDAT = 1'b0;
  logic          iCoreSVAL = 1'b0;
  logic [CW-1:0] oCoefData;
  logic          oCoefValid;
  logic [4:0]    oCoefIdx;
  logic          oCoefLast;

  initial forever #5 iClk = ~iClk;

  dct_serial_frame_ctrl #(.DW(DW), .CW(CW), .TMO(TMO)) dut (
    .iClk(iClk), .iRst(iRst), .iCfgSize(iCfgSize), .iStart(iStart),
    .oBusy(oBusy), .oDone(oDone), .oErr(oErr),
    .iSmpData(iSmpData), .iSmpValid(iSmpValid), .oSmpReady(oSmpReady),
    .oCoreSize(oCoreSize), .oCoreValid(oCoreValid), .oCoreSDAT(oCoreSDAT), .oCoreSVAL(oCoreSVAL),
    .iCoreSDAT(iCoreSDAT), .iCoreSVAL(iCoreSVAL),
    .oCoefData(oCoefData), .oCoefValid(oCoefValid), .oCoefIdx(oCoefIdx), .oCoefLast(oCoefLast)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor state, written only by the monitor process.
  int cyc = 0, cv_cnt = 0, cv_cyc = 0, last_sval_cyc = 0, err_cnt = 0, err_cyc = 0;
  int done_cnt = 0, busy_cnt = 0, rdy_cnt = 0;
  logic busy_at_done = 1'b0, busy_after_done = 1'b1, prev_done = 1'b0;
  logic          tx_bits[$];
  logic [CW-1:0] cf_dat_q[$];
  logic [4:0]    cf_idx_q[$];
  logic          cf_last_q[$];
  logic          cf_done_q[$];

  initial forever begin
    @(negedge iClk);
    cyc++;
    if (oCoreSVAL) begin tx_bits.push_back(oCoreSDAT); last_sval_cyc = cyc; end
    if (oCoreValid) begin cv_cnt++; cv_cyc = cyc; end
    if (oErr) begin err_cnt++; err_cyc = cyc; end
    if (oBusy) busy_cnt++;
    if (oSmpReady) rdy_cnt++;
    if (oCoefValid) begin
      cf_dat_q.push_back(oCoefData);
      cf_idx_q.push_back(oCoefIdx);
      cf_last_q.push_back(oCoefLast);
      cf_done_q.push_back(oDone);
    end
    if (oDone) begin done_cnt++; busy_at_done = oBusy; end
    if (prev_done) busy_after_done = oBusy;
    prev_done = oDone;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  logic [DW-1:0] smp   [32];
  logic [CW-1:0] coefs [32];
  int feed_to = 0;
  int stall_sval = 0, stall_rdy = 0;

  task automatic tick();
    @(negedge iClk);
    #1;
  endtask

  function automatic logic [63:0] outs();
    return 64'({oBusy, oDone, oErr, oSmpReady, oCoreSize, oCoreValid, oCoreSDAT, oCoreSVAL,
                oCoefData, oCoefValid, oCoefIdx, oCoefLast});
  endfunction

  function automatic logic [DW-1:0] tx_word(input int base, input int k);
    logic [DW-1:0] w = '0;
    for (int b = 0; b < DW; b++) begin
      int p = base + k * DW + b;
      w = {w[DW-2:0], (p < tx_bits.size()) ? tx_bits[p] : 1'bx};
    end
    return w;
  endfunction

  task automatic start_block(input logic [2:0] sz);
    iCfgSize = sz;
    iStart   = 1'b1;
    tick();
    iStart   = 1'b0;
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!oSmpReady && guard < 300) begin tick(); guard++; end
    if (guard >= 300) feed_to++;
  endtask

  // Sends cnt samples; at sample stall_at, valid is held low for 10 LOAD cycles.
  task automatic feed(input int cnt, input int stall_at);
    for (int k = 0; k < cnt; k++) begin
      if (k == stall_at) begin
        iSmpValid = 1'b0;
        wait_ready();
        stall_sval = 0;
        stall_rdy  = 0;
        for (int s = 0; s < 10; s++) begin
          stall_sval += int'(oCoreSVAL);
          stall_rdy  += int'(oSmpReady);
          tick();
        end
      end
      iSmpData  = smp[k];
      iSmpValid = 1'b1;
      wait_ready();
      tick();
    end
    iSmpValid = 1'b0;
  endtask

  task automatic core_send(input int cnt, input int maxgap);
    for (int i = 0; i < cnt; i++) begin
      for (int b = CW - 1; b >= 0; b--) begin
        int gap = int'($urandom_range(0, maxgap));
        iCoreSVAL = 1'b0;
        repeat (gap) tick();
        iCoreSVAL = 1'b1;
        iCoreSDAT = coefs[i][b];
        tick();
      end
    end
    iCoreSVAL = 1'b0;
    iCoreSDAT = 1'b0;
  endtask

  task automatic wait_coefs(input int base, input int cnt);
    int guard = 0;
    while (cf_dat_q.size() < base + cnt && guard < 6000) begin tick(); guard++; end
    tick();
    tick();
    chk_eq("coef_count", 64'(cf_dat_q.size() - base), 64'(cnt));
  endtask

  initial begin
    int tx_base, cf_base, cv0, d0, e0, b0, r0, errs, nlast, last_at;

    repeat (3) tick();
    chk_eq("reset_outputs", outs(), 64'd0);
    iRst = 1'b0;
    tick();

    // Block 1: 4-point, valid held, core replies with random gaps.
    smp[0] = 16'h8001; smp[1] = 16'h0002; smp[2] = 16'h0004; smp[3] = 16'hFFFF;
    coefs[0] = 16'h1234; coefs[1] = 16'h0000; coefs[2] = 16'hFFFF; coefs[3] = 16'h8000;
    tx_base = tx_bits.size(); cf_base = cf_dat_q.size(); cv0 = cv_cnt; d0 = done_cnt;
    start_block(SZ_4);
    chk_eq("b1_core_valid_start", oCoreValid, 1'b1);
    chk_eq("b1_busy_start", oBusy, 1'b1);
    feed(4, -1);
    core_send(4, 2);
    wait_coefs(cf_base, 4);
    chk_eq("b1_tx_bits", 64'(tx_bits.size() - tx_base), 64'd64);
    for (int k = 0; k < 4; k++) chk_eq($sformatf("b1_tx_smp%0d", k), tx_word(tx_base, k), smp[k]);
    chk_eq("b1_start_to_wait", 64'(last_sval_cyc + 1 - cv_cyc), 64'd69);
    chk_eq("b1_core_valid_cycles", 64'(cv_cnt - cv0), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk_eq($sformatf("b1_coef%0d_dat", i), cf_dat_q[cf_base + i], coefs[i]);
      chk_eq($sformatf("b1_coef%0d_idx", i), cf_idx_q[cf_base + i], 64'(i));
      chk_eq($sformatf("b1_coef%0d_last", i), cf_last_q[cf_base + i], (i == 3));
      chk_eq($sformatf("b1_coef%0d_done", i), cf_done_q[cf_base + i], (i == 3));
    end
    chk_eq("b1_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk_eq("b1_busy_at_done", busy_at_done, 1'b1);
    chk_eq("b1_busy_after_done", busy_after_done, 1'b0);
    chk_eq("b1_feed_timeouts", 64'(feed_to), 64'd0);

    // Reserved size: error pulse only.
    e0 = err_cnt; b0 = busy_cnt; cv0 = cv_cnt; r0 = rdy_cnt;
    iCfgSize = 3'd5; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    repeat (4) tick();
    chk_eq("rsv_err_cycles", 64'(err_cnt - e0), 64'd1);
    chk_eq("rsv_busy_cycles", 64'(busy_cnt - b0), 64'd0);
    chk_eq("rsv_core_valid", 64'(cv_cnt - cv0), 64'd0);
    chk_eq("rsv_smp_ready", 64'(rdy_cnt - r0), 64'd0);

    // Block 2: 32-point with an input stall and an ignored restart.
    for (int k = 0; k < 32; k++) begin
      smp[k]   = DW'(k * 32'h0813) ^ 16'hA55A;
      coefs[k] = {k[7:0], ~k[7:0]};
    end
    tx_base = tx_bits.size(); cf_base = cf_dat_q.size(); cv0 = cv_cnt; d0 = done_cnt;
    start_block(SZ_32);
    iCfgSize = SZ_4; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    chk_eq("b2_size_held", oCoreSize, SZ_32);
    feed(32, 13);
    chk_eq("b2_stall_sval", 64'(stall_sval), 64'd0);
    chk_eq("b2_stall_ready", 64'(stall_rdy), 64'd10);
    core_send(32, 1);
    wait_coefs(cf_base, 32);
    errs = 0;
    for (int k = 0; k < 32; k++) if (tx_word(tx_base, k) !== smp[k]) errs++;
    chk_eq("b2_tx_word_errs", 64'(errs), 64'd0);
    chk_eq("b2_tx_bits", 64'(tx_bits.size() - tx_base), 64'd512);
    errs = 0; nlast = 0; last_at = -1;
    for (int i = 0; i < 32 && cf_base + i < cf_dat_q.size(); i++) begin
      if (cf_dat_q[cf_base + i] !== coefs[i] || cf_idx_q[cf_base + i] !== 5'(i)) errs++;
      if (cf_last_q[cf_base + i]) begin nlast++; last_at = int'(cf_idx_q[cf_base + i]); end
    end
    chk_eq("b2_coef_errs", 64'(errs), 64'd0);
    chk_eq("b2_last_count", 64'(nlast), 64'd1);
    chk_eq("b2_last_idx", 64'(last_at), 64'd31);
    chk_eq("b2_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk_eq("b2_core_valid_cycles", 64'(cv_cnt - cv0), 64'd1);
    chk_eq("b2_feed_timeouts", 64'(feed_to), 64'd0);

    // Block 3: core stays silent, watchdog fires.
    smp[0] = 16'h1111; smp[1] = 16'h2222; smp[2] = 16'h4444; smp[3] = 16'h8888;
    cf_base = cf_dat_q.size(); e0 = err_cnt; d0 = done_cnt;
    start_block(SZ_4);
    feed(4, -1);
    begin
      int guard = 0;
      while (err_cnt == e0 && guard < 3000) begin tick(); guard++; end
    end
    chk_eq("wd_err_cycles", 64'(err_cnt - e0), 64'd1);
    chk_eq("wd_latency", 64'(err_cyc - (last_sval_cyc + 1)), 64'(TMO));
    chk_eq("wd_no_done", 64'(done_cnt - d0), 64'd0);
    chk_eq("wd_no_coef", 64'(cf_dat_q.size() - cf_base), 64'd0);
    tick();
    chk_eq("wd_idle_after", oBusy, 1'b0);

    // Block 4: normal block after the abort.
    coefs[0] = 16'hA5A5; coefs[1] = 16'h0F0F; coefs[2] = 16'h7001; coefs[3] = 16'h0003;
    cf_base = cf_dat_q.size(); d0 = done_cnt;
    start_block(SZ_4);
    feed(4, -1);
    core_send(4, 0);
    wait_coefs(cf_base, 4);
    chk_eq("b4_coef2_dat", cf_dat_q[cf_base + 2], 16'h7001);
    chk_eq("b4_coef3_last", cf_last_q[cf_base + 3], 1'b1);
    chk_eq("b4_done_pulses", 64'(done_cnt - d0), 64'd1);

    // Reset in the middle of shifting a sample out.
    start_block(SZ_8);
    iSmpData = 16'hC3C3; iSmpValid = 1'b1;
    wait_ready();
    tick();
    iSmpValid = 1'b0;
    repeat (5) tick();
    chk_eq("rst_pre_shifting", oCoreSVAL, 1'b1);
    iRst = 1'b1;
    tick();
    chk_eq("rst_mid_outputs", outs(), 64'd0);
    iRst = 1'b0;
    cf_base = cf_dat_q.size(); b0 = busy_cnt; d0 = done_cnt;
    for (int i = 0; i < 40; i++) begin
      iCoreSVAL = 1'b1;
      iCoreSDAT = i[0];
      tick();
    end
    iCoreSVAL = 1'b0;
    repeat (3) tick();
    chk_eq("rst_no_coef", 64'(cf_dat_q.size() - cf_base), 64'd0);
    chk_eq("rst_no_busy", 64'(busy_cnt - b0), 64'd0);
    chk_eq("rst_no_done", 64'(done_cnt - d0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dct_serial_frame_ctrl.md
Name: dct_serial_frame_ctrl

Overview:
- Sequences one transform block through the serial DCT core.
- Accepts parallel samples over a valid/ready stream, drives the core's iSize/iValid/iSDAT/iSVAL serial input MSB-first, then deserializes the core's oSDAT/oSVAL output into indexed parallel coefficients.
- Sits between the system sample buffer and the DCT top, as the core's only driver.

Parameters:
- DW, 16, input sample width (bits serialized per sample)
- CW, 16, output coefficient width (bits collected per coefficient)
- TMO, 1024, watchdog limit in cycles without iCoreSVAL while awaiting coefficients

Ports:
- iClk  in  1  clock
- iRst  in  1  synchronous reset, active-high
- iCfgSize  in  3  0/1/2/3 = 4/8/16/32-point block (N = 4<<size); 4..7 reserved
- iStart  in  1  start one block (sampled only in IDLE)
- oBusy  out  1  block in progress
- oDone  out  1  one-cycle pulse on the last coefficient
- oErr  out  1  one-cycle pulse: reserved size or watchdog abort
- iSmpData  in  DW  sample
- iSmpValid  in  1  sample valid
- oSmpReady  out  1  sample accepted when valid&ready
- oCoreSize  out  3  size to core
- oCoreValid  out  1  block-start strobe to core
- oCoreSDAT  out  1  serial data to core
- oCoreSVAL  out  1  serial valid to core
- iCoreSDAT  in  1  serial data from core
- iCoreSVAL  in  1  serial valid from core
- oCoefData  out  CW  coefficient
- oCoefValid  out  1  coefficient strobe (no backpressure)
- oCoefIdx  out  5  coefficient index 0..N-1
- oCoefLast  out  1  with oCoefValid when idx = N-1

Behaviour:
- Reset (and iRst mid-operation): all outputs 0, FSM to IDLE, all counters and shift registers cleared, any block in progress discarded.
- TX FSM states: IDLE, START, LOAD, SHIFT, WAIT.
  - IDLE: iStart with reserved size -> oErr pulse, stay in IDLE. iStart with valid size -> latch size onto oCoreSize (held until return to IDLE); next state START; oBusy=1 from the next cycle.
  - START: oCoreValid=1 for exactly one cycle -> LOAD.
  - LOAD: oSmpReady=1. On handshake, load the shift register and go to SHIFT. The handshake cycle drives no serial bit.
  - SHIFT: oCoreSVAL=1 for DW consecutive cycles, oCoreSDAT = sample MSB first. After bit 0: if samples sent < N -> LOAD, else WAIT.
  - Timing: an N-sample block with no input stalls takes 1 + N*(DW+1) cycles from START to entering WAIT.
  - WAIT: serial outputs 0. On the RX last coefficient -> IDLE, oBusy=0 the cycle after oDone.
- RX deserializer is active only while oBusy; iCoreSVAL in IDLE is ignored.
  - Each iCoreSVAL cycle shifts iCoreSDAT in MSB-first and increments the bit counter. Gaps (SVAL low) hold the counter.
  - On the CW-th bit: oCoefValid=1 the next cycle with oCoefData and oCoefIdx; index increments.
  - Index N-1: oCoefLast=1 and oDone=1 in the same cycle; RX counters clear.
  - RX may overlap TX, since the core may emit early; it is sequenced independently.
- Watchdog: runs only in WAIT; counts cycles since the last iCoreSVAL; reloads on each iCoreSVAL. Reaching TMO -> oErr pulse, abort to IDLE, no oDone, partial word discarded.
- iStart while busy is ignored. iCfgSize changes while busy have no effect.
- No oCoefValid is emitted after an abort.

Decomposition:
- Shared package dct_ctrl_pkg:
  - size encoding constants SZ_4/SZ_8/SZ_16/SZ_32
  - function size_to_n
  - TX state enum
- Sub-module dct_serdes_rx: the deserializer with bit/index counters. The TX FSM, serializer and watchdog stay in the parent.

Test Plan:
- Size=0, DW=16, samples 0x8001,0x0002,0x0004,0xFFFF with valid held -> oCoreValid 1 cycle after START entry; SDAT for the first sample is 1,0..0,1; WAIT reached 1+4*17=69 cycles after START entry.
- Core model returns 4 coefficients 0x1234,0x0000,0xFFFF,0x8000 with random SVAL gaps -> oCoefIdx 0..3 with matching data; oCoefLast and oDone on idx 3; oBusy drops the next cycle.
- iStart with iCfgSize=5 -> oErr 1 cycle; oBusy, oCoreValid and oSmpReady stay 0.
- Size=3: iSmpValid deasserted for 10 cycles mid-block -> oCoreSVAL low throughout the stall, no bit lost; 32 coefficients, oCoefLast at idx 31.
- Core silent after TX completes, TMO=1024 -> oErr exactly 1024 cycles after WAIT entry (no iCoreSVAL); back to IDLE; a subsequent block runs normally.
- iRst asserted mid-SHIFT -> next cycle all outputs 0; iCoreSVAL pulses afterwards produce no oCoefValid; iStart during the block ignored.
